// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the instruction/data memory port arbiter.
package mem_arb_pkg;

   // Consecutive denied fetch cycles tolerated before fetch is forced through.
   localparam int STARVE_LIMIT_DEF = 4;

   // Which requester owns the response returning from memory this cycle.
   typedef enum logic [1:0] {
      OWN_NONE  = 2'd0,
      OWN_FETCH = 2'd1,
      OWN_DATA  = 2'd2
   } owner_e;

endpackage

// File: rtl/mem_lane_align.sv
// Maps a 32-bit data access onto the 64-bit memory word: write replication,
// byte-mask placement and read half selection.
module mem_lane_align (
   input  logic [31:0] wdata,
   input  logic [3:0]  be,
   input  logic        wsel,
   input  logic [63:0] rdata,
   input  logic        rsel,
   output logic [63:0] wdata_rep,
   output logic [7:0]  wmask,
   output logic [31:0] rdata_sel
);

   // Same word in both halves so only the mask decides which lane is written.
   always_comb begin
      wdata_rep = {wdata, wdata};
      wmask     = wsel ? {be, 4'b0000} : {4'b0000, be};
      rdata_sel = rsel ? rdata[63:32] : rdata[31:0];
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one 64-bit single-cycle-latency memory port between instruction
// fetch and data access. Data wins by default; fetch is forced through after
// STARVE_LIMIT consecutive denied cycles. Responses are routed one cycle
// later by a registered owner.
//
// owner state | meaning
// ------------+------------------------------------------------------
// OWN_NONE    | no read issued last cycle (idle, write, or reset)
// OWN_FETCH   | fetch read issued last cycle; mem_rdata goes to fetch
// OWN_DATA    | data load issued last cycle; mem_rdata half goes to data
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   input  logic        if_flush,
   output logic        if_stall,
   output logic [63:0] if_rdata,
   output logic        if_rvalid,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [3:0]  d_be,
   output logic        d_stall,
   output logic [31:0] d_rdata,
   output logic        d_rvalid,
   output logic        mem_en,
   output logic        mem_we,
   output logic [28:0] mem_addr,
   output logic [63:0] mem_wdata,
   output logic [7:0]  mem_wmask,
   input  logic [63:0] mem_rdata
);

   localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   owner_e           owner_q, owner_d;
   logic [CNT_W-1:0] starve_q, starve_d;
   logic             hsel_q, hsel_d;
   logic             fetch_gnt;
   logic             data_gnt;
   logic [63:0]      wdata_rep;
   logic [7:0]       wmask;
   logic [31:0]      rdata_sel;

   // Sub-doubleword address bits play no part in a doubleword port.
   logic             unused_addr_bits;
   assign unused_addr_bits = ^{if_addr[2:0], d_addr[1:0]};

   mem_lane_align u_lane_align (
      .wdata     (d_wdata),
      .be        (d_be),
      .wsel      (d_addr[2]),
      .rdata     (mem_rdata),
      .rsel      (hsel_q),
      .wdata_rep (wdata_rep),
      .wmask     (wmask),
      .rdata_sel (rdata_sel)
   );

   // Grant: data first unless fetch has starved long enough; nothing in reset.
   always_comb begin
      fetch_gnt = 1'b0;
      data_gnt  = 1'b0;
      if (!reset) begin
         if (if_req && (!d_req || (starve_q == LIMIT))) begin
            fetch_gnt = 1'b1;
         end else if (d_req) begin
            data_gnt = 1'b1;
         end
      end
   end

   // Starvation count saturates at the limit and clears whenever fetch is served or idle.
   always_comb begin
      starve_d = starve_q;
      if (!if_req || fetch_gnt) begin
         starve_d = '0;
      end else if (starve_q != LIMIT) begin
         starve_d = starve_q + 1'b1;
      end
   end

   // Next owner: writes complete on grant, so they leave no response to route.
   always_comb begin
      owner_d = OWN_NONE;
      hsel_d  = d_addr[2];
      if (fetch_gnt) begin
         owner_d = OWN_FETCH;
      end else if (data_gnt && !d_we) begin
         owner_d = OWN_DATA;
      end
   end

   // State register; reset drops any pending response.
   always_ff @(posedge clk) begin
      if (reset) begin
         owner_q  <= OWN_NONE;
         starve_q <= '0;
         hsel_q   <= 1'b0;
      end else begin
         owner_q  <= owner_d;
         starve_q <= starve_d;
         hsel_q   <= hsel_d;
      end
   end

   // Outputs: request-cycle memory drive plus next-cycle response routing.
   always_comb begin
      if_stall  = if_req & ~fetch_gnt & ~reset;
      d_stall   = d_req & ~data_gnt & ~reset;
      mem_en    = fetch_gnt | data_gnt;
      mem_we    = data_gnt & d_we;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_wmask = '0;
      if (fetch_gnt) begin
         mem_addr = if_addr[31:3];
      end else if (data_gnt) begin
         mem_addr = d_addr[31:3];
      end
      if (mem_we) begin
         mem_wdata = wdata_rep;
         mem_wmask = wmask;
      end
      if_rvalid = !reset && (owner_q == OWN_FETCH) && !if_flush;
      d_rvalid  = !reset && (owner_q == OWN_DATA);
      if_rdata  = reset ? 64'd0 : mem_rdata;
      d_rdata   = reset ? 32'd0 : rdata_sel;
   end

endmodule
